// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a small
// first-word-fall-through byte FIFO with a valid/ready read port.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rxs
// START     | half-bit wait, then re-check start bit (glitch filter)
// DATA      | sampling 8 data bits LSB-first at bit centres
// STOP      | sampling the stop bit; push byte or flag framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    logic        rx_meta;
    logic        rxs;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic [7:0]  sh;
    logic [7:0]  sh_nxt;
    logic        push_nxt;
    logic        fe_nxt;
    logic        push_req;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;
    logic          push_ok;

    // Both flops reset high so a reset never fabricates a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            sh        <= sh_nxt;
            push_req  <= push_nxt;
            frame_err <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        push_nxt  = 1'b0;
        fe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_M1;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        cnt_nxt   = FULL_M1;
                        idx_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    sh_nxt  = {rxs, sh[7:1]};
                    cnt_nxt = FULL_M1;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        push_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        fe_nxt    = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // sh is stable for many cycles after the stop bit, so the push reads it directly.
    assign rd_valid = (fifo_count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;
    assign pop      = rd_valid & rd_ready;
    assign push_ok  = push_req & ((fifo_count < CW'(FIFO_DEPTH)) | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= sh;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push_ok) begin
                fifo_count <= fifo_count - CW'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level reference model (byte queue plus
// scheduled push/error events) compared against the DUT every cycle.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int H     = CPB / 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    // Edges from the edge that first samples the start bit low to the FIFO
    // update (PUSH_LAT) or to the edge that raises frame_err (FE_LAT).
    localparam int PUSH_LAT = 3 + H + 9 * CPB;
    localparam int FE_LAT   = 2 + H + 9 * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic          rd_ready = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] fifo_count;
    logic          frame_err;
    logic          overflow;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_at;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_fe = 1'b0;
    int         edge_n = 0;
    bit         chk_en = 1'b0;
    bit         mdl_pop;
    bit         mdl_push;
    logic [7:0] mdl_pd;
    ev_t        mdl_ev;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] pop_log[$];
    int         fe_seen = 0;
    bit         done = 1'b0;
    int         ready_w = 6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Reference model: advance one clock edge.
    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            m_q.delete();
            ev_q.delete();
            m_ovf = 1'b0;
            m_fe  = 1'b0;
        end else begin
            mdl_pop  = (m_q.size() > 0) && rd_ready;
            mdl_push = 1'b0;
            mdl_pd   = 8'h00;
            m_fe     = 1'b0;
            while (ev_q.size() > 0 && ev_q[0].edge_at <= edge_n) begin
                mdl_ev = ev_q.pop_front();
                if (mdl_ev.ok) begin
                    mdl_push = 1'b1;
                    mdl_pd   = mdl_ev.data;
                end else begin
                    m_fe = 1'b1;
                end
            end
            if (mdl_pop) void'(m_q.pop_front());
            if (mdl_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(mdl_pd);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_valid", rd_valid, (m_q.size() > 0));
            check("rd_data", rd_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
            check("fifo_count", fifo_count, m_q.size());
            check("frame_err", frame_err, m_fe);
            check("overflow", overflow, m_ovf);
            if (rd_valid && rd_ready) pop_log.push_back(rd_data);
            if (frame_err) fe_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int extra_low);
        ev_t e;
        e.edge_at = edge_n + 1 + (stop_ok ? PUSH_LAT : FE_LAT);
        e.data    = d;
        e.ok      = stop_ok;
        ev_q.push_back(e);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB + (stop_ok ? 0 : extra_low));
        rx = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        rx    = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int p_edge;
        logic [7:0] d99;
        tick(3);
        chk_en = 1'b1;
        reset  = 1'b0;
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overflow", overflow, 0);
        tick(5);

        // back-to-back frames, consumer always ready
        rd_ready = 1'b1;
        pop_log.delete();
        send_frame(8'h55, 1'b1, 0);
        send_frame(8'hA3, 1'b1, 0);
        tick(10);
        check("b2b count", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            check("b2b first", pop_log[0], 8'h55);
            check("b2b second", pop_log[1], 8'hA3);
        end

        // framing error followed by a good byte
        pop_log.delete();
        fe_seen = 0;
        send_frame(8'hA5, 1'b0, 0);
        tick(CPB);
        send_frame(8'h3C, 1'b1, 0);
        tick(10);
        check("ferr pulses", fe_seen, 1);
        check("ferr pops", pop_log.size(), 1);
        if (pop_log.size() == 1) check("after ferr byte", pop_log[0], 8'h3C);

        // short glitch on the line
        pop_log.delete();
        fe_seen = 0;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch pops", pop_log.size(), 0);
        check("glitch ferr", fe_seen, 0);

        // fill past full with consumer stalled
        rd_ready = 1'b0;
        for (int b = 0; b <= 16; b++) send_frame(8'(b), 1'b1, 0);
        tick(10);
        check("full count", fifo_count, 16);
        check("full overflow", overflow, 1);
        pop_log.delete();
        rd_ready = 1'b1;
        tick(24);
        rd_ready = 1'b0;
        check("drain count", pop_log.size(), 16);
        for (int i = 0; i < pop_log.size(); i++) check("drain order", pop_log[i], i);
        pulse_reset();
        tick(4);

        // push and pop in the same cycle while full
        for (int b = 0; b < 16; b++) send_frame(8'(8'hE0 + b), 1'b1, 0);
        tick(4);
        p_edge = edge_n + 1 + PUSH_LAT;
        fork
            send_frame(8'h77, 1'b1, 0);
            begin
                while (edge_n < p_edge - 1) tick(1);
                rd_ready = 1'b1;
                tick(1);
                rd_ready = 1'b0;
            end
        join
        tick(4);
        check("simul count", fifo_count, 16);
        check("simul overflow", overflow, 0);
        pop_log.delete();
        rd_ready = 1'b1;
        tick(24);
        check("simul drain count", pop_log.size(), 16);
        if (pop_log.size() == 16) begin
            check("simul drain first", pop_log[0], 8'hE1);
            check("simul drain last", pop_log[15], 8'h77);
        end

        // reset mid-frame with bytes queued
        rd_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        tick(4);
        check("pre-reset count", fifo_count, 2);
        d99 = 8'h99;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = d99[i];
            tick(CPB);
        end
        rx = d99[4];
        tick(H);
        pulse_reset();
        check("rst rd_valid", rd_valid, 0);
        check("rst rd_data", rd_data, 0);
        check("rst fifo_count", fifo_count, 0);
        check("rst frame_err", frame_err, 0);
        check("rst overflow", overflow, 0);
        tick(2 * CPB);
        send_frame(8'h42, 1'b1, 0);
        tick(4);
        check("post-reset count", fifo_count, 1);
        check("post-reset data", rd_data, 8'h42);
        rd_ready = 1'b1;
        tick(4);

        // randomized traffic
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    bit ok;
                    ready_w = (i < 30) ? 6 : 1;
                    ok = ($urandom_range(0, 99) < 85);
                    send_frame(8'($urandom), ok, ok ? 0 : int'($urandom_range(0, 3 * CPB)));
                    tick(ok ? int'($urandom_range(0, 2 * CPB)) : CPB + int'($urandom_range(0, CPB)));
                end
                tick(40);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rd_ready = ($urandom_range(0, 7) < ready_w);
                    tick(1);
                end
            end
        join
        rd_ready = 1'b1;
        tick(2 * DEPTH);
        check("final empty", fifo_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive stage that consumes the 8N1 UART `TX` line driven by the fabric-master top level and turns it into buffered bytes. It oversamples the line with a cycle counter, deserializes LSB-first, checks the stop bit and pushes good bytes into a small first-word-fall-through FIFO with a valid/ready read port. It serves as the on-chip console receiver in simulation benches and hardware loopback designs.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range 8..65535.
- `FIFO_DEPTH`, 16, byte entries; power of two, 2..256.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one cycle sufficient.
- `rx`  in  1  asynchronous serial input, idle high.
- `rd_data`  out  8  head-of-FIFO byte; valid only while `rd_valid`=1.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts `rd_data` when `rd_valid`&`rd_ready`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overflow`  out  1  sticky: a good byte was dropped because FIFO full; cleared only by `reset`.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Single bit counter `cnt` (16 bits), bit index `idx` (3 bits), shift register `sh` (8 bits).
- IDLE: on `rxs`=0 go START, load `cnt`=CLKS_PER_BIT/2−1 (integer divide).
- START: decrement `cnt`; at 0 sample `rxs`: 1 → IDLE (glitch rejected, nothing reported); 0 → DATA, `cnt`=CLKS_PER_BIT−1, `idx`=0.
- DATA: at `cnt`=0 shift `rxs` into `sh` MSB (LSB-first reception), reload `cnt`; after `idx`=7 go STOP.
- STOP: at `cnt`=0 sample `rxs`: 1 → push `sh`, go IDLE; 0 → pulse `frame_err`, discard byte, go WAIT_IDLE.
- WAIT_IDLE: stay until `rxs`=1, then IDLE (a break condition produces exactly one `frame_err`).
- Push is accepted when `fifo_count`<FIFO_DEPTH, or when a pop occurs in the same cycle (occupancy unchanged). Otherwise byte dropped and `overflow` set.
- Pop when `rd_valid`&`rd_ready`; pop on empty FIFO impossible (`rd_valid`=0).
- Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; `fifo_count` tracked separately.
- Reset mid-frame: FSM to IDLE, counters cleared, FIFO emptied, `overflow` cleared; a frame in progress is abandoned and the next falling edge after `rxs` returns high starts a fresh frame (if `rx` is low at reset release, the FSM treats it as a start edge and glitch/framing rules apply).

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `fifo_count`=0, `frame_err`=0, `overflow`=0; FSM IDLE.
- `rx` to `rxs` latency: 2 cycles.
- START entered the cycle after `rxs` first seen low; bit k (k=0..7) sampled CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT cycles after START entry; stop bit at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- Push registered in the cycle after the stop-bit sample; `rd_valid`/`rd_data`/`fifo_count` reflect it on the following cycle (FWFT, registered outputs).
- `frame_err` asserted for exactly the cycle after the stop-bit sample.
- Pop: `rd_data` advances to next entry and `fifo_count` decrements the cycle after the handshake; back-to-back pops every cycle supported.
- Minimum frame spacing accepted: stop bit followed immediately by next start bit (no extra idle).

## Test plan
- CLKS_PER_BIT=16, `rd_ready`=1: send 0x55 then 0xA3 back-to-back → `rd_data` 0x55 then 0xA3, each `rd_valid` one cycle, `frame_err`=0, `overflow`=0.
- Send 0xA5 with stop bit low, then line high → one `frame_err` pulse, `fifo_count` stays 0; following 0x3C received correctly.
- Drive `rx` low for 4 cycles then high (CLKS_PER_BIT=16) → no state beyond START, no push, no `frame_err`.
- FIFO_DEPTH=16, `rd_ready`=0, send bytes 0x00..0x10 → `fifo_count`=16, `overflow`=1, then draining yields 0x00..0x0F in order; 0x10 lost.
- With FIFO full, hold `rd_ready`=1 exactly on the push cycle of byte 0x77 → accepted, `fifo_count` stays 16, `overflow` remains 0, 0x77 last out.
- Assert `reset` for 1 cycle during DATA bit 4 of 0x99 with 2 bytes queued → all outputs at reset values next cycle; subsequent 0x42 received as sole byte.
